minirisc_seq_ctrl: RTL and testbench



---
 rtl/minirisc_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_minirisc_seq_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/minirisc_seq_ctrl.sv
// minirisc_seq_ctrl -- multi-cycle instruction sequencer for the MiniRISC core.
//
// Steps each instruction through FETCH, DECODE, EXEC, (MEM), WB. It gates the
// decoder's control bits into one-cycle write strobes and handshakes with the
// instruction and data memories. A memory request held without an ack for
// MEM_TIMEOUT cycles parks the sequencer in ERR. HALT and ERR are left only
// through rst.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   run               level; start/continue execution (sampled in IDLE and WB)
//   imem_req/ack      instruction fetch handshake; ir_load = IR capture strobe
//   dec_*             decoder outputs for the instruction held in IR
//   dmem_req/we/ack   data memory handshake (dmem_we qualifies dmem_req)
//   flags_we, reg_we, pc_we   one-cycle write strobes
//   halted, bus_err   in HALT / ERR state
//   state             current state encoding (IDLE=0 .. ERR=7)
//   instr_count       retired-instruction count, wraps modulo 2^CNT_W
module minirisc_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_load,
  input  logic             dec_halt,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_reg_write,
  input  logic             dec_comp_enb,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             flags_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic             halted,
  output logic             bus_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_e;

  // Wait counter value seen during the MEM_TIMEOUT-th request cycle.
  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  // wait_d defaults to zero and only advances while a request stays
  // unanswered, so every entry into FETCH or MEM starts from a clean count.
  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    count_d  = count_q;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    flags_we = 1'b0;
    reg_we   = 1'b0;
    pc_we    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
        // An ack in the final permitted cycle takes priority over the timeout.
        if (imem_ack)                state_d = S_DECODE;
        else if (wait_q == LAST_WAIT) state_d = S_ERR;
        else                         wait_d  = wait_q + 8'd1;
      end
      S_DECODE: begin
        state_d = dec_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        flags_we = dec_comp_enb;
        if (dec_mem_read && dec_mem_write)      state_d = S_ERR;
        else if (dec_mem_read || dec_mem_write) state_d = S_MEM;
        else                                    state_d = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_write;
        if (dmem_ack)                 state_d = S_WB;
        else if (wait_q == LAST_WAIT) state_d = S_ERR;
        else                          wait_d  = wait_q + 8'd1;
      end
      S_WB: begin
        pc_we   = 1'b1;
        reg_we  = dec_reg_write;
        count_d = count_q + CNT_W'(1);
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT, S_ERR: begin
        state_d = state_q;
      end
      default: state_d = S_ERR;
    endcase
  end

  assign halted      = (state_q == S_HALT);
  assign bus_err     = (state_q == S_ERR);
  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_minirisc_seq_ctrl.sv
// Bench for minirisc_seq_ctrl (MEM_TIMEOUT=4, CNT_W=4). Expected per-cycle
// outputs are queued as stimulus is driven and compared at the next negedge.
module tb_minirisc_seq_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5,
                         ST_HALT = 3'd6, ST_ERR = 3'd7;

  // Output vector bits: {imem_req, ir_load, dmem_req, dmem_we, flags_we,
  //                      reg_we, pc_we, halted, bus_err}
  localparam logic [8:0] O_IREQ = 9'h100, O_IRL = 9'h080, O_DREQ = 9'h040,
                         O_DWE  = 9'h020, O_FWE = 9'h010, O_RWE  = 9'h008,
                         O_PWE  = 9'h004, O_HLT = 9'h002, O_ERR  = 9'h001;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst, run, imem_ack, dmem_ack;
  logic dec_halt, dec_mem_read, dec_mem_write, dec_reg_write, dec_comp_enb;
  logic imem_req, ir_load, dmem_req, dmem_we, flags_we, reg_we, pc_we;
  logic halted, bus_err;
  logic [2:0] state;
  logic [3:0] instr_count;

  minirisc_seq_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
    .dec_halt(dec_halt), .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write), .dec_reg_write(dec_reg_write),
    .dec_comp_enb(dec_comp_enb),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .flags_we(flags_we), .reg_we(reg_we), .pc_we(pc_we),
    .halted(halted), .bus_err(bus_err), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [8:0] outs;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [3:0] exp_cnt = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, "/state"}, 32'(state), 32'(e.st));
      check({e.tag, "/outs"},
            32'({imem_req, ir_load, dmem_req, dmem_we, flags_we, reg_we, pc_we, halted, bus_err}),
            32'(e.outs));
      check({e.tag, "/count"}, 32'(instr_count), 32'(e.cnt));
    end
  end

  // Queue the expectation for the current cycle, then advance to just after
  // the next rising edge where the following cycle's inputs are driven.
  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [8:0] outs);
    exp_t e;
    e.tag = tag; e.st = st; e.outs = outs; e.cnt = exp_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting in FETCH. fw fetch wait cycles precede the
  // ack; dw >= TIMEOUT means the data access never gets acked.
  task automatic do_instr(input string tag, input int fw, input logic h,
                          input logic mr, input logic mw, input logic rw,
                          input logic ce, input int dw, input logic run_after);
    dec_halt = h; dec_mem_read = mr; dec_mem_write = mw;
    dec_reg_write = rw; dec_comp_enb = ce;
    imem_ack = 1'b0;
    for (int i = 0; i < fw; i++) expect_cyc({tag, "/fetch_wait"}, ST_FETCH, O_IREQ);
    imem_ack = 1'b1;
    expect_cyc({tag, "/fetch"}, ST_FETCH, O_IREQ | O_IRL);
    imem_ack = 1'b0;
    expect_cyc({tag, "/decode"}, ST_DECODE, 9'h0);
    if (h) return;
    expect_cyc({tag, "/exec"}, ST_EXEC, ce ? O_FWE : 9'h0);
    if (mr && mw) return;
    if (mr || mw) begin
      run = run_after;
      dmem_ack = 1'b0;
      if (dw >= TIMEOUT) begin
        for (int i = 0; i < TIMEOUT; i++)
          expect_cyc({tag, "/mem_wait"}, ST_MEM, O_DREQ | (mw ? O_DWE : 9'h0));
        return;
      end
      for (int i = 0; i < dw; i++)
        expect_cyc({tag, "/mem_wait"}, ST_MEM, O_DREQ | (mw ? O_DWE : 9'h0));
      dmem_ack = 1'b1;
      expect_cyc({tag, "/mem_ack"}, ST_MEM, O_DREQ | (mw ? O_DWE : 9'h0));
      dmem_ack = 1'b0;
    end
    run = run_after;
    expect_cyc({tag, "/wb"}, ST_WB, (rw ? O_RWE : 9'h0) | O_PWE);
    exp_cnt = exp_cnt + 4'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    dec_halt = 1'b0; dec_mem_read = 1'b0; dec_mem_write = 1'b0;
    dec_reg_write = 1'b0; dec_comp_enb = 1'b0;
    @(posedge clk);
    #1;
    expect_cyc("reset", ST_IDLE, 9'h0);
    rst = 1'b0;
    repeat (10) expect_cyc("idle", ST_IDLE, 9'h0);

    // ALU, load, then store with run dropped during MEM.
    run = 1'b1;
    expect_cyc("idle_go", ST_IDLE, 9'h0);
    do_instr("alu", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1);
    do_instr("load", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3, 1'b1);
    do_instr("store", 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    repeat (2) expect_cyc("store_idle", ST_IDLE, 9'h0);

    // Fetch acked in the last permitted cycle.
    run = 1'b1;
    expect_cyc("idle_go2", ST_IDLE, 9'h0);
    do_instr("fetch_ack4", TIMEOUT - 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);

    // Fetch timeout: ERR sticky even with acks and run.
    imem_ack = 1'b0;
    repeat (TIMEOUT) expect_cyc("ftimeout_wait", ST_FETCH, O_IREQ);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (3) expect_cyc("ftimeout_err", ST_ERR, O_ERR);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    rst = 1'b1;
    expect_cyc("rst_from_err", ST_ERR, O_ERR);
    exp_cnt = '0;
    rst = 1'b0; run = 1'b0;
    expect_cyc("after_rst", ST_IDLE, 9'h0);

    // 16 retired instructions wrap the 4-bit counter back to 0.
    run = 1'b1;
    expect_cyc("idle_go3", ST_IDLE, 9'h0);
    repeat (16) do_instr("wrap", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);

    // Halt; its fetch cycle also confirms the wrapped count of 0.
    do_instr("halt", 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (3) expect_cyc("halted", ST_HALT, O_HLT);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    rst = 1'b1;
    expect_cyc("rst_from_halt", ST_HALT, O_HLT);
    exp_cnt = '0;
    rst = 1'b0;

    // Read and write together is illegal.
    expect_cyc("idle_go4", ST_IDLE, 9'h0);
    do_instr("conflict", 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    repeat (2) expect_cyc("conflict_err", ST_ERR, O_ERR);
    rst = 1'b1;
    expect_cyc("rst_conflict", ST_ERR, O_ERR);
    rst = 1'b0;

    // Data access timeout.
    expect_cyc("idle_go5", ST_IDLE, 9'h0);
    do_instr("dtimeout", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, TIMEOUT, 1'b1);
    repeat (2) expect_cyc("dtimeout_err", ST_ERR, O_ERR);
    rst = 1'b1;
    expect_cyc("rst_dtimeout", ST_ERR, O_ERR);
    rst = 1'b0;

    // Reset in the middle of a data access.
    expect_cyc("idle_go6", ST_IDLE, 9'h0);
    dec_halt = 1'b0; dec_mem_read = 1'b1; dec_mem_write = 1'b0;
    dec_reg_write = 1'b1; dec_comp_enb = 1'b0;
    imem_ack = 1'b1;
    expect_cyc("midmem/fetch", ST_FETCH, O_IREQ | O_IRL);
    imem_ack = 1'b0;
    expect_cyc("midmem/decode", ST_DECODE, 9'h0);
    expect_cyc("midmem/exec", ST_EXEC, 9'h0);
    expect_cyc("midmem/mem", ST_MEM, O_DREQ);
    rst = 1'b1;
    expect_cyc("midmem/rst", ST_MEM, O_DREQ);
    rst = 1'b0; run = 1'b0;
    expect_cyc("midmem/idle", ST_IDLE, 9'h0);
    expect_cyc("midmem/idle2", ST_IDLE, 9'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
